// File: rtl/tx_request_arbiter.sv
// Round-robin arbiter that shares one data_transmitter among N_REQ requesters.
// It latches the winner's word, strobes tx_send, tracks tx_busy, and returns done or error to the winner.
module tx_request_arbiter #(
  parameter int N_REQ         = 4,
  parameter int DATA_W        = 64,
  parameter int START_TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        error,
  output logic                    tx_send,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic                    arb_busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TMR_W = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LAUNCH     = 3'd1,
    WAIT_START = 3'd2,
    WAIT_DONE  = 3'd3,
    COMPLETE   = 3'd4
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   last_grant_reg, last_grant_next;
  logic [TMR_W-1:0]   timer_reg, timer_next;
  logic [N_REQ-1:0]   grant_reg, grant_next;
  logic [N_REQ-1:0]   done_reg, done_next;
  logic [N_REQ-1:0]   error_reg, error_next;
  logic               tx_send_reg, tx_send_next;
  logic [DATA_W-1:0]  tx_data_reg, tx_data_next;
  logic               arb_busy_reg, arb_busy_next;

  logic [N_REQ*IDX_W-1:0] rot_idx;
  logic [N_REQ-1:0]       rot_req;
  logic [N_REQ-1:0]       winner_onehot;
  logic [IDX_W-1:0]       winner;
  logic                   winner_valid;
  logic [DATA_W-1:0]      winner_data;
  logic                   launch_now;
  logic                   timeout_hit;

  // Slot gi of the rotated view is the requester gi+1 places after the last grant.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot_idx[gi*IDX_W +: IDX_W] = IDX_W'((int'(last_grant_reg) + gi + 1) % N_REQ);
      assign rot_req[gi]                = req[rot_idx[gi*IDX_W +: IDX_W]];
      assign winner_onehot[gi]          = (winner == IDX_W'(gi));
    end
  endgenerate

  always_comb begin
    winner       = '0;
    winner_valid = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        winner       = rot_idx[k*IDX_W +: IDX_W];
        winner_valid = 1'b1;
      end
    end
  end

  assign winner_data = req_data[int'(winner)*DATA_W +: DATA_W];
  assign launch_now  = winner_valid && !tx_busy;
  // Fires so that error becomes visible START_TIMEOUT cycles after tx_send.
  assign timeout_hit = (int'(timer_reg) + 1) >= (START_TIMEOUT - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_grant_reg <= IDX_W'(N_REQ - 1);
      timer_reg      <= '0;
      grant_reg      <= '0;
      done_reg       <= '0;
      error_reg      <= '0;
      tx_send_reg    <= 1'b0;
      tx_data_reg    <= '0;
      arb_busy_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      timer_reg      <= timer_next;
      grant_reg      <= grant_next;
      done_reg       <= done_next;
      error_reg      <= error_next;
      tx_send_reg    <= tx_send_next;
      tx_data_reg    <= tx_data_next;
      arb_busy_reg   <= arb_busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:       if (launch_now) state_next = LAUNCH;
      LAUNCH:     state_next = WAIT_START;
      WAIT_START: begin
        if (tx_busy)          state_next = WAIT_DONE;
        else if (timeout_hit) state_next = IDLE;
      end
      WAIT_DONE:  if (!tx_busy) state_next = COMPLETE;
      COMPLETE:   state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_comb begin
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    timer_next      = timer_reg;
    grant_next      = grant_reg;
    done_next       = '0;
    error_next      = '0;
    tx_send_next    = 1'b0;
    tx_data_next    = tx_data_reg;
    arb_busy_next   = (state_next != IDLE);
    case (state_reg)
      IDLE: begin
        grant_next = '0;
        if (launch_now) begin
          owner_next   = winner;
          grant_next   = winner_onehot;
          tx_data_next = winner_data;
          tx_send_next = 1'b1;
        end
      end
      LAUNCH: timer_next = '0;
      WAIT_START: begin
        if (!tx_busy) begin
          if (timer_reg < TMR_W'(START_TIMEOUT)) timer_next = timer_reg + 1'b1;
          if (timeout_hit) begin
            error_next      = grant_reg;
            grant_next      = '0;
            last_grant_next = owner_reg;
          end
        end
      end
      COMPLETE: begin
        done_next       = grant_reg;
        grant_next      = '0;
        last_grant_next = owner_reg;
      end
      default: ;
    endcase
  end

  assign grant    = grant_reg;
  assign done     = done_reg;
  assign error    = error_reg;
  assign tx_send  = tx_send_reg;
  assign tx_data  = tx_data_reg;
  assign arb_busy = arb_busy_reg;

endmodule
